mips_data_mem_arbiter: RTL

- Two-port round-robin arbiter sharing the single-port `mips_cpu_data_memory` between the CPU data port (requester 0) and a debug/DMA loader port (requester 1).
- Each accepted request is serialised into one memory strobe cycle.
- Read data returns to the owning requester after a fixed, parameterised memory read latency.
- Sits between `mips_cpu_harvard` and the data memory in the harvard top level and testbenches.

---
 rtl/mips_data_mem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mips_data_mem_arbiter.sv
// Round-robin arbiter that shares the single-port data memory between the CPU
// data port (requester 0) and a debug/DMA loader port (requester 1).
//
// Each accepted request becomes exactly one memory strobe cycle (ACCESS). Reads
// then wait RD_LATENCY-1 cycles (WAIT) and capture mem_readdata (CAPTURE). The
// owner's rvalid pulses high in the cycle after CAPTURE.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   clk_enable          global stall; all registers hold while low
//   reqN_valid/write/address/writedata   request from requester N
//   reqN_ready          request accepted this cycle (combinational)
//   reqN_rvalid/rdata   one-cycle read response pulse and held read data
//   mem_address/write/read/writedata/readdata   single-port memory interface
//   busy                high whenever the arbiter is not idle
module mips_data_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,

  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [DATA_W-1:0] req0_writedata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [DATA_W-1:0] req1_writedata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,

  output logic              busy
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAccess  = 2'd1;
  localparam logic [1:0] StWait    = 2'd2;
  localparam logic [1:0] StCapture = 2'd3;

  // WAIT lasts RD_LATENCY-1 cycles; the counter runs down to zero inclusive.
  localparam logic [1:0] WaitInit = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       last_grant_q;  // id of the most recently granted requester
  logic       id_q;          // owner of the in-flight access
  logic       write_q;       // in-flight access is a write

  logic gnt0, gnt1;
  logic accept;
  logic sel_write;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_grant_q);
    gnt1 = req1_valid && (!req0_valid || !last_grant_q);
  end

  assign req0_ready = (state_q == StIdle) && clk_enable && gnt0;
  assign req1_ready = (state_q == StIdle) && clk_enable && gnt1;
  assign accept     = req0_ready || req1_ready;
  assign sel_write  = req1_ready ? req1_write : req0_write;
  assign busy       = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StAccess;
      end
      StAccess: begin
        if (write_q) begin
          state_d = StIdle;
        end else if (RD_LATENCY > 1) begin
          state_d = StWait;
          cnt_d   = WaitInit;
        end else begin
          state_d = StCapture;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) state_d = StCapture;
        else               cnt_d   = cnt_q - 2'd1;
      end
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= 2'd0;
      last_grant_q  <= 1'b1;
      id_q          <= 1'b0;
      write_q       <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      req0_rvalid   <= 1'b0;
      req1_rvalid   <= 1'b0;
      req0_rdata    <= '0;
      req1_rdata    <= '0;
    end else if (clk_enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      // Strobes are registered so they are high exactly during ACCESS.
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if (accept) begin
        id_q          <= req1_ready;
        last_grant_q  <= req1_ready;
        write_q       <= sel_write;
        mem_address   <= req1_ready ? req1_address : req0_address;
        mem_writedata <= req1_ready ? req1_writedata : req0_writedata;
        mem_write     <= sel_write;
        mem_read      <= !sel_write;
      end

      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      if (state_q == StCapture) begin
        if (id_q) begin
          req1_rvalid <= 1'b1;
          req1_rdata  <= mem_readdata;
        end else begin
          req0_rvalid <= 1'b1;
          req0_rdata  <= mem_readdata;
        end
      end
    end
  end

endmodule
